stopwatch_core: RTL
===================

Name: stopwatch_core

Overview:
- Consumes the 10 Hz square wave from the clock divider and produces a 4-digit BCD stopwatch value, format M:SS.t (max 9:59.9).
- Provides start/stop, clear and lap-hold control.
- Digit outputs feed the display multiplexer directly downstream.
- Everything runs in the 100 MHz system clock domain. clk_10Hz is sampled as data and is never used as a clock.

Parameters:
- WRAP_EN, 1, 1 = roll over 9:59.9 -> 0:00.0 and keep running; 0 = saturate at 9:59.9 and go to PAUSE.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset: synchronous, active-high (asserted = 1), despite the suffix.
- clk_10Hz  in  1  divider output, same clk domain, 50% duty, one rising edge per 0.1 s.
- start_stop  in  1  single-cycle pulse, already debounced; toggles run/stop.
- clear  in  1  single-cycle pulse; zeroes the time when stopped.
- lap  in  1  single-cycle pulse; toggles display freeze while running.
- tenths  out  4  BCD 0-9, displayed value.
- sec_ones  out  4  BCD 0-9.
- sec_tens  out  4  BCD 0-5.
- min_ones  out  4  BCD 0-9.
- running  out  1  high in RUN or LAP.
- lap_active  out  1  high in LAP.
- ovf  out  1  one-cycle pulse when a tick arrives at 9:59.9.

Behaviour:
- Reset, when rst_n=1 at a clk edge:
  - State = IDLE; internal count 0:00.0; lap latch 0:00.0.
  - Outputs all 0: running=0, lap_active=0, ovf=0.
  - clk_10Hz_d = 1, so no spurious tick after reset even if clk_10Hz is already high.
  - Reset mid-count discards everything; it has priority over all inputs.
- Tick detection:
  - clk_10Hz_d <= clk_10Hz every cycle.
  - tick = clk_10Hz & ~clk_10Hz_d.
  - Exactly one tick per 0 -> 1 transition.
- Count increment:
  - On a clk edge where tick=1 and state is RUN or LAP, the internal count increments by 0.1 s.
  - The new value is visible on the outputs after that edge (1 cycle latency from tick).
- BCD carry chain:
  - tenths 9 -> 0, carries into sec_ones.
  - sec_ones 9 -> 0, carries into sec_tens.
  - sec_tens 5 -> 0, carries into min_ones.
  - min_ones 9 = terminal.
- At 9:59.9 with a tick:
  - ovf=1 for that single cycle.
  - WRAP_EN=1: count -> 0:00.0 and state is unchanged.
  - WRAP_EN=0: count holds 9:59.9 and state -> PAUSE.
- State machine (IDLE, RUN, PAUSE, LAP):
  - IDLE: start_stop -> RUN. clear: stay IDLE. lap ignored.
  - RUN: start_stop -> PAUSE. lap -> LAP and latch the current count (including any same-cycle increment) into the lap register. clear ignored.
  - LAP: start_stop -> PAUSE. lap -> RUN. clear ignored. Counting continues internally.
  - PAUSE: start_stop -> RUN. clear -> IDLE and count := 0:00.0. lap ignored.
- Priority when pulses coincide:
  - Reset > clear > start_stop > lap.
  - In PAUSE, clear+start_stop -> IDLE.
  - In RUN/LAP, start_stop+lap -> PAUSE.
- Tick coincident with start_stop in RUN/LAP: the tick is counted, then state = PAUSE.
- Tick in IDLE/PAUSE: ignored.
- Display selection:
  - In LAP the digit outputs show the lap register.
  - In every other state they show the live count.
  - Leaving LAP via start_stop shows the live (stopped) count on the next cycle.
- Digit outputs are registered or driven by a registered mux only. No combinational path from inputs to outputs.
- The internal count never holds a non-BCD value.

Test Plan:
- Reset release: hold rst_n=1 with clk_10Hz=1, then release -> no tick; outputs 0:00.0, running=0, for 3 clk_10Hz periods with no start.
- Basic count: start_stop pulse, then 25 clk_10Hz rising edges -> outputs 0:02.5, running=1. Each increment appears exactly 1 clk after the cycle clk_10Hz first samples 1.
- Carry chain, WRAP_EN=1: run to 0:59.9, one tick -> 1:00.0. Run to 9:59.9, one tick -> 0:00.0 with ovf high for exactly 1 cycle and running still 1.
- Saturate, WRAP_EN=0: at 9:59.9, one tick -> holds 9:59.9, ovf for 1 cycle, running=0. A further 5 ticks cause no change.
- Lap: at 0:03.0 pulse lap, then 10 ticks -> outputs stay 0:03.0 with lap_active=1. Pulse lap -> outputs 0:04.0 the next cycle.
- Control edge cases:
  - clear in RUN -> ignored.
  - start_stop coincident with a tick at 0:00.4 -> 0:00.5 and PAUSE.
  - clear+start_stop together in PAUSE -> IDLE 0:00.0.
  - rst_n asserted mid-LAP -> next cycle IDLE, 0:00.0, lap_active=0.

Source files
------------

// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if: control pulses, 10 Hz input and display/status outputs of the stopwatch
interface stopwatch_core_if;
    logic       clk_10Hz;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] tenths;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic       running;
    logic       lap_active;
    logic       ovf;
    modport master (
        output clk_10Hz, start_stop, clear, lap,
        input  tenths, sec_ones, sec_tens, min_ones, running, lap_active, ovf
    );
    modport slave (
        input  clk_10Hz, start_stop, clear, lap,
        output tenths, sec_ones, sec_tens, min_ones, running, lap_active, ovf
    );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core: M:SS.t BCD stopwatch counting 10 Hz edges, with run/stop, clear and lap hold
module stopwatch_core #(
    parameter bit WRAP_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    stopwatch_core_if.slave sw
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
    state_t     r_state, w_next;
    logic       r_clk_d, r_ovf;
    logic [3:0] r_t, r_s, r_st, r_m;
    logic [3:0] r_lt, r_ls, r_lst, r_lm;
    logic [3:0] w_t, w_s, w_st, w_m;
    logic       w_tick, w_inc, w_c1, w_c2, w_c3, w_term, w_sat, w_clr, w_latch;

    assign w_tick = sw.clk_10Hz & ~r_clk_d;
    assign w_inc  = w_tick & (r_state == RUN || r_state == LAP);
    assign w_c1   = r_t == 4'd9;
    assign w_c2   = w_c1 & (r_s == 4'd9);
    assign w_c3   = w_c2 & (r_st == 4'd5);
    assign w_term = w_c3 & (r_m == 4'd9);
    assign w_sat  = w_inc & w_term & ~WRAP_EN;

    // next live count: BCD carry chain, held when idle or saturating
    always_comb begin
        w_t  = r_t;
        w_s  = r_s;
        w_st = r_st;
        w_m  = r_m;
        if (w_inc && !w_sat) begin
            w_t  = w_c1 ? 4'd0 : r_t + 4'd1;
            w_s  = w_c2 ? 4'd0 : w_c1 ? r_s + 4'd1 : r_s;
            w_st = w_c3 ? 4'd0 : w_c2 ? r_st + 4'd1 : r_st;
            w_m  = w_term ? 4'd0 : w_c3 ? r_m + 4'd1 : r_m;
        end
    end

    // next state; clear beats start_stop beats lap, saturation forces a stop
    always_comb begin
        w_next  = r_state;
        w_clr   = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            IDLE:    if (!sw.clear && sw.start_stop) w_next = RUN;
            RUN:     if (sw.start_stop || w_sat) w_next = PAUSE;
                     else if (sw.lap) begin
                         w_next  = LAP;
                         w_latch = 1'b1;
                     end
            LAP:     if (sw.start_stop || w_sat) w_next = PAUSE;
                     else if (sw.lap) w_next = RUN;
                     else w_next = LAP;
            PAUSE:   if (sw.clear) begin
                         w_next = IDLE;
                         w_clr  = 1'b1;
                     end else if (sw.start_stop) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    // state, edge detector, live count and lap latch; the edge history resets high to suppress a post-reset tick
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_clk_d <= 1'b1;
            r_ovf   <= 1'b0;
            {r_m, r_st, r_s, r_t}     <= '0;
            {r_lm, r_lst, r_ls, r_lt} <= '0;
        end else begin
            r_state <= w_next;
            r_clk_d <= sw.clk_10Hz;
            r_ovf   <= w_inc & w_term;
            {r_m, r_st, r_s, r_t} <= w_clr ? 16'd0 : {w_m, w_st, w_s, w_t};
            if (w_latch) {r_lm, r_lst, r_ls, r_lt} <= {w_m, w_st, w_s, w_t};
        end
    end

    assign sw.tenths     = (r_state == LAP) ? r_lt  : r_t;
    assign sw.sec_ones   = (r_state == LAP) ? r_ls  : r_s;
    assign sw.sec_tens   = (r_state == LAP) ? r_lst : r_st;
    assign sw.min_ones   = (r_state == LAP) ? r_lm  : r_m;
    assign sw.running    = (r_state == RUN) || (r_state == LAP);
    assign sw.lap_active = r_state == LAP;
    assign sw.ovf        = r_ovf;
endmodule
